// File: rtl/fft16_digit_reverse_buffer.sv
// Radix-4 digit-reverse output reorder for the 16-point FFT, ping-pong banked.
// Define FFT_OUT_SCALE_EN to apply the 1/N (>>>4) output normalisation.
module fft16_digit_reverse_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_start,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  output logic              out_start,
  output logic [3:0]        out_index,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_im,
  output logic              frame_err
);

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [3:0] wcnt;
  logic [3:0] rcnt;
  logic       wbank;
  logic       rbank;
  logic [1:0] full;

  logic [DATA_W-1:0] mem_re [32];
  logic [DATA_W-1:0] mem_im [32];

  logic              restart;
  logic              wdone;
  logic              rdone;
  logic [3:0]        waddr;
  logic [1:0]        full_set;
  logic [1:0]        full_clr;
  logic [DATA_W-1:0] rd_re;
  logic [DATA_W-1:0] rd_im;

  // A start mid-frame drops the partial frame and restarts at position 0
  assign restart = in_valid && in_start
                && (wcnt != 4'd0);
  assign waddr   = restart ? 4'd0
                 : {wcnt[1:0], wcnt[3:2]};
  assign wdone   = in_valid && !restart
                && (wcnt == 4'd15);
  assign rdone   = (state_q == READ)
                && (rcnt == 4'd15);

  assign full_set = wdone ? (2'b01 << wbank)
                  : 2'b00;
  assign full_clr = rdone ? (2'b01 << rbank)
                  : 2'b00;

`ifdef FFT_OUT_SCALE_EN
  assign rd_re = $signed(mem_re[{rbank, rcnt}]) >>> 4;
  assign rd_im = $signed(mem_im[{rbank, rcnt}]) >>> 4;
`else
  assign rd_re = mem_re[{rbank, rcnt}];
  assign rd_im = mem_im[{rbank, rcnt}];
`endif

  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem_re[{wbank, waddr}] <= in_real;
      mem_im[{wbank, waddr}] <= in_im;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt      <= 4'd0;
      wbank     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= restart;
      if (in_valid) begin
        wcnt <= restart ? 4'd1 : wcnt + 4'd1;
        if (wdone) begin
          wbank <= ~wbank;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 2'b00;
    end else begin
      full <= (full & ~full_clr) | full_set;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (full[rbank]) begin
          state_d = READ;
        end
      end
      READ: begin
        // Stay in READ across banks when the next frame is already waiting
        if (rdone && !full[~rbank]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rcnt    <= 4'd0;
      rbank   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == READ) begin
        rcnt <= rcnt + 4'd1;
      end else begin
        rcnt <= 4'd0;
      end
      if (rdone) begin
        rbank <= ~rbank;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_index <= 4'd0;
      out_real  <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= (state_q == READ);
      if (state_q == READ) begin
        out_start <= (rcnt == 4'd0);
        out_index <= rcnt;
        out_real  <= rd_re;
        out_im    <= rd_im;
      end else begin
        out_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft16_digit_reverse_buffer.sv
// Directed bench for fft16_digit_reverse_buffer.
// Build with FFT_OUT_SCALE_EN to exercise the scaled output path.
module tb_fft16_digit_reverse_buffer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_start;
  logic [W-1:0] in_real;
  logic [W-1:0] in_im;
  logic         out_valid;
  logic         out_start;
  logic [3:0]   out_index;
  logic [W-1:0] out_real;
  logic [W-1:0] out_im;
  logic         frame_err;

  fft16_digit_reverse_buffer #(.DATA_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .in_real   (in_real),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_start (out_start),
    .out_index (out_index),
    .out_real  (out_real),
    .out_im    (out_im),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    int   idx;
    int   re;
    int   im;
    logic st;
  } obs_t;

  obs_t oq[$];
  int   cyc = 0;
  int   ferr_cnt = 0;
  int   ferr_cyc = -1;
  int   n_chk = 0;
  int   n_fail = 0;

  // Bin k holds input position exp_p[k]
  int exp_p [16] = '{0, 4, 8, 12, 1, 5, 9, 13,
                     2, 6, 10, 14, 3, 7, 11, 15};

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      oq.push_back('{cyc, int'(out_index),
                     int'($signed(out_real)),
                     int'($signed(out_im)),
                     out_start});
    end
    if (frame_err) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic int sc(input int v);
`ifdef FFT_OUT_SCALE_EN
    return v >>> 4;
`else
    return v;
`endif
  endfunction

  task automatic drive(input logic st, input int v);
    in_valid = 1'b1;
    in_start = st;
    in_real  = v;
    in_im    = -v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    oq.delete();
    ferr_cnt = 0;
    ferr_cyc = -1;
  endtask

  task automatic check_size(input string nm, input int n);
    n_chk++;
    if (oq.size() != n) begin
      n_fail++;
      $display("FAIL %s count: got %0d want %0d",
               nm, oq.size(), n);
    end
  endtask

  task automatic check_frame(input string nm, input int base,
                             input int t0, input int qi);
    for (int k = 0; k < 16; k++) begin
      int   v;
      obs_t o;
      v = base + exp_p[k];
      n_chk++;
      if (qi + k >= oq.size()) begin
        n_fail++;
        $display("FAIL %s bin %0d: missing, want re=%0d",
                 nm, k, sc(v));
      end else begin
        o = oq[qi + k];
        if (o.cyc !== t0 + k || o.idx !== k ||
            o.re !== sc(v) || o.im !== sc(-v) ||
            o.st !== (k == 0)) begin
          n_fail++;
          $display("FAIL %s bin %0d: got cyc=%0d idx=%0d re=%0d im=%0d st=%0b want cyc=%0d idx=%0d re=%0d im=%0d st=%0b",
                   nm, k, o.cyc, o.idx, o.re, o.im, o.st,
                   t0 + k, k, sc(v), sc(-v), k == 0);
        end
      end
    end
  endtask

  task automatic check_idle_outs(input string nm);
    n_chk++;
    if (out_valid !== 1'b0 || out_start !== 1'b0 ||
        out_index !== 4'd0 || out_real !== '0 ||
        out_im !== '0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got v=%0b s=%0b i=%0d re=%0h im=%0h fe=%0b want all 0",
               nm, out_valid, out_start, out_index,
               out_real, out_im, frame_err);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_real  = '0;
    in_im    = '0;
    #1;
    check_idle_outs("reset_async");
    idle(3);
    check_idle_outs("reset_held");
    reset = 1'b0;
    idle(2);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release out_valid: got %0b want 0",
               out_valid);
    end
  endtask

  task automatic test_single_frame();
    int e;
    clear_obs();
    for (int p = 0; p < 16; p++) begin
      drive(p == 0, p);
    end
    e = cyc;
    idle(20);
    check_size("single", 16);
    check_frame("single", 0, e + 2, 0);
    n_chk++;
    if (ferr_cnt != 0) begin
      n_fail++;
      $display("FAIL single frame_err: got %0d pulses want 0",
               ferr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int e [3];
    clear_obs();
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 16; p++) begin
        drive(p == 0, 16 * f + p);
      end
      e[f] = cyc;
    end
    idle(25);
    check_size("b2b", 48);
    check_frame("b2b_f0", 0, e[0] + 2, 0);
    check_frame("b2b_f1", 16, e[0] + 18, 16);
    check_frame("b2b_f2", 32, e[0] + 34, 32);
  endtask

  task automatic test_gapped();
    int e;
    clear_obs();
    for (int p = 0; p < 16; p++) begin
      drive(p == 0, 100 + p);
      if (p < 15) idle(1);
    end
    e = cyc;
    idle(20);
    check_size("gapped", 16);
    check_frame("gapped", 100, e + 2, 0);
  endtask

  task automatic test_restart();
    int es;
    int e;
    clear_obs();
    for (int p = 0; p < 7; p++) begin
      drive(p == 0, 500 + p);
    end
    for (int p = 0; p < 16; p++) begin
      drive(p == 0, 200 + p);
      if (p == 0) es = cyc;
    end
    e = cyc;
    idle(20);
    n_chk++;
    if (ferr_cnt != 1 || ferr_cyc != es) begin
      n_fail++;
      $display("FAIL restart frame_err: got %0d pulses at %0d want 1 at %0d",
               ferr_cnt, ferr_cyc, es);
    end
    check_size("restart", 16);
    check_frame("restart", 200, e + 2, 0);
  endtask

  task automatic test_reset_read();
    bit found = 0;
    clear_obs();
    for (int p = 0; p < 16; p++) begin
      drive(p == 0, 300 + p);
    end
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_index == 4'd5) found = 1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL rst_read wait: bin 5 never seen");
    end
    #2;
    reset = 1'b1;
    #1;
    check_idle_outs("rst_read_async");
    idle(2);
    check_idle_outs("rst_read_held");
    reset = 1'b0;
    idle(2);
    clear_obs();
    for (int p = 0; p < 16; p++) begin
      drive(p == 0, 400 + p);
    end
    begin
      int e;
      e = cyc;
      idle(20);
      check_size("rst_fresh", 16);
      check_frame("rst_fresh", 400, e + 2, 0);
    end
  endtask

`ifdef FFT_OUT_SCALE_EN
  task automatic test_scale();
    int e;
    int vals [3];
    int want [3];
    vals = '{160, -17, 15};
    want = '{10, -2, 0};
    clear_obs();
    for (int p = 0; p < 16; p++) begin
      drive(p == 0, (p < 3) ? vals[p] : 0);
    end
    e = cyc;
    idle(20);
    check_size("scale", 16);
    for (int p = 0; p < 3; p++) begin
      n_chk++;
      if (oq.size() < 16) begin
        n_fail++;
        $display("FAIL scale p%0d: missing want %0d",
                 p, want[p]);
      end else if (oq[4 * p].re !== want[p] ||
                   oq[4 * p].cyc !== e + 2 + 4 * p) begin
        n_fail++;
        $display("FAIL scale p%0d: got %0d at %0d want %0d at %0d",
                 p, oq[4 * p].re, oq[4 * p].cyc,
                 want[p], e + 2 + 4 * p);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_restart();
    test_reset_read();
`ifdef FFT_OUT_SCALE_EN
    test_scale();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
